xnor_match_unit: RTL and testbench

XNOR_MATCH_UNIT -- requirements
Module: xnor_match_unit

---
 rtl/xnor_match_unit.sv | 122 ++++++++++++
 tb/tb_xnor_match_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xnor_match_unit.sv
// Two-stage masked XNOR/XOR comparator with similarity count, equality flag,
// threshold hit and a saturating hit counter.
module xnor_match_unit #(
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 16,
  localparam int SW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mask,
  input  logic             mode,
  input  logic [SW-1:0]    thresh,
  input  logic             clr_cnt,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic [SW-1:0]    sim,
  output logic             eq,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt
);

  // Stage 1: match vector, mode-selected raw vector, mask and threshold
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_m_reg;
  logic [WIDTH-1:0] s1_raw_reg;
  logic [WIDTH-1:0] s1_mask_reg;
  logic [SW-1:0]    s1_thresh_reg;
  logic [WIDTH-1:0] m_next;

  assign m_next = ~(a ^ b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= in_valid;
    end
  end

  // Payload needs no reset: it is only consumed when s1_valid_reg is set.
  always_ff @(posedge clk) begin
    if (rst_n && in_valid) begin
      s1_m_reg      <= m_next;
      s1_raw_reg    <= mode ? ~m_next : m_next;
      s1_mask_reg   <= mask;
      s1_thresh_reg <= thresh;
    end
  end

  // Stage 2 combinational reduction
  logic [WIDTH-1:0] match_bits;
  logic [WIDTH-1:0] care_ok;
  logic [SW-1:0]    sim_next;
  logic             eq_next;
  logic             hit_next;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign match_bits[gi] = s1_m_reg[gi] & s1_mask_reg[gi];
      assign care_ok[gi]    = s1_m_reg[gi] | ~s1_mask_reg[gi];
    end
  endgenerate

  always_comb begin
    sim_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sim_next = sim_next + SW'(match_bits[i]);
    end
  end

  assign eq_next  = &care_ok;
  assign hit_next = (sim_next >= s1_thresh_reg);

  // Stage 2 registers; results hold while no new valid arrives
  logic             out_valid_reg;
  logic [WIDTH-1:0] y_reg;
  logic [SW-1:0]    sim_reg;
  logic             eq_reg;
  logic             hit_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      sim_reg       <= '0;
      eq_reg        <= 1'b0;
      hit_reg       <= 1'b0;
    end else begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        y_reg   <= s1_raw_reg;
        sim_reg <= sim_next;
        eq_reg  <= eq_next;
        hit_reg <= hit_next;
      end
    end
  end

  // Hit counter counts visible hit pulses; clear wins over increment
  logic [CNT_W-1:0] hit_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_reg <= '0;
    end else if (clr_cnt) begin
      hit_cnt_reg <= '0;
    end else if (out_valid_reg && hit_reg && (hit_cnt_reg != {CNT_W{1'b1}})) begin
      hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_reg;
  assign y         = y_reg;
  assign sim       = sim_reg;
  assign eq        = eq_reg;
  assign hit       = hit_reg;
  assign hit_cnt   = hit_cnt_reg;

endmodule

// File: tb/tb_xnor_match_unit.sv
// Bench for xnor_match_unit: directed cases plus a randomized run scored
// against a bit-counting reference model.
module tb_xnor_match_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a, b, mask;
  logic        mode;
  logic [3:0]  thresh;
  logic        clr_cnt;
  logic        out_valid;
  logic [7:0]  y;
  logic [3:0]  sim;
  logic        eq, hit;
  logic [15:0] hit_cnt;
  logic        s_out_valid;
  logic [7:0]  s_y;
  logic [3:0]  s_sim;
  logic        s_eq, s_hit;
  logic [1:0]  s_hit_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         due;
    logic [7:0] y;
    logic [3:0] sim;
    logic       eq;
    logic       hit;
  } exp_t;

  always #5 clk = ~clk;

  xnor_match_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .mask(mask),
    .mode(mode), .thresh(thresh), .clr_cnt(clr_cnt), .out_valid(out_valid),
    .y(y), .sim(sim), .eq(eq), .hit(hit), .hit_cnt(hit_cnt)
  );

  xnor_match_unit #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .mask(mask),
    .mode(mode), .thresh(thresh), .clr_cnt(clr_cnt), .out_valid(s_out_valid),
    .y(s_y), .sim(s_sim), .eq(s_eq), .hit(s_hit), .hit_cnt(s_hit_cnt)
  );

  // Reference: count masked positions where a and b agree.
  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                 input logic [7:0] mm, input logic md,
                                 input logic [3:0] th);
    exp_t r;
    int same = 0;
    int care = 0;
    for (int i = 0; i < 8; i++) begin
      if (mm[i]) begin
        care++;
        if (ma[i] == mb[i]) same++;
      end
    end
    r.due = 0;
    r.y   = md ? (ma ^ mb) : ~(ma ^ mb);
    r.sim = 4'(same);
    r.eq  = (same == care);
    r.hit = (same >= int'(th));
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] im, input logic md, input logic [3:0] th);
    in_valid = v; a = ia; b = ib; mask = im; mode = md; thresh = th;
  endtask

  // Presents one valid input across one sampling edge, then idles the inputs.
  task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] im,
                      input logic md, input logic [3:0] th);
    set_in(1'b1, ia, ib, im, md, th);
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr_cnt = 1'b0;
    set_in(1'b1, 8'hA5, 8'hA5, 8'hFF, 1'b0, 4'd0);
    step();
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ov[%0d]: got %b want 0", k, out_valid); end
      checks++; if ({y, sim, eq, hit} !== 14'd0) begin errors++; $display("FAIL rst_outs[%0d]: got y=%h sim=%0d eq=%b hit=%b want all 0", k, y, sim, eq, hit); end
      checks++; if (hit_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt[%0d]: got %0d want 0", k, hit_cnt); end
      step();
    end
    $display("test_reset done");
  endtask

  task automatic test_directed();
    do_reset();
    // equal operands, full mask
    send(8'hA5, 8'hA5, 8'hFF, 1'b0, 4'd8);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL d1_early: out_valid=%b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL d1_ov: got %b want 1", out_valid); end
    checks++; if ({y, sim, eq, hit} !== {8'hFF, 4'd8, 1'b1, 1'b1}) begin errors++; $display("FAIL d1_res: got y=%h sim=%0d eq=%b hit=%b want FF 8 1 1", y, sim, eq, hit); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL d1_pulse: got %b want 0", out_valid); end
    checks++; if (hit_cnt !== 16'd1) begin errors++; $display("FAIL d1_cnt: got %0d want 1", hit_cnt); end
    checks++; if ({y, sim, eq, hit} !== {8'hFF, 4'd8, 1'b1, 1'b1}) begin errors++; $display("FAIL d1_hold: got y=%h sim=%0d eq=%b hit=%b want FF 8 1 1", y, sim, eq, hit); end
    $display("directed A5/A5 mode0 thr8: y=%h sim=%0d eq=%b hit=%b cnt=%0d", y, sim, eq, hit, hit_cnt);
    // complementary operands, XOR mode
    send(8'hF0, 8'h0F, 8'hFF, 1'b1, 4'd1);
    step();
    checks++; if ({out_valid, y, sim, eq, hit} !== {1'b1, 8'hFF, 4'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL d2_res: got ov=%b y=%h sim=%0d eq=%b hit=%b want 1 FF 0 0 0", out_valid, y, sim, eq, hit); end
    step();
    checks++; if (hit_cnt !== 16'd1) begin errors++; $display("FAIL d2_cnt: got %0d want 1", hit_cnt); end
    $display("directed F0/0F mode1 thr1: y=%h sim=%0d eq=%b hit=%b cnt=%0d", y, sim, eq, hit, hit_cnt);
    // partial mask, threshold met then above WIDTH
    send(8'h3C, 8'h0C, 8'h0F, 1'b0, 4'd4);
    step();
    checks++; if ({out_valid, y, sim, eq, hit} !== {1'b1, 8'hCF, 4'd4, 1'b1, 1'b1}) begin errors++; $display("FAIL d3_res: got ov=%b y=%h sim=%0d eq=%b hit=%b want 1 CF 4 1 1", out_valid, y, sim, eq, hit); end
    send(8'h3C, 8'h0C, 8'h0F, 1'b0, 4'd9);
    step();
    checks++; if ({out_valid, y, sim, eq, hit} !== {1'b1, 8'hCF, 4'd4, 1'b1, 1'b0}) begin errors++; $display("FAIL d4_res: got ov=%b y=%h sim=%0d eq=%b hit=%b want 1 CF 4 1 0", out_valid, y, sim, eq, hit); end
    step();
    checks++; if (hit_cnt !== 16'd2) begin errors++; $display("FAIL d4_cnt: got %0d want 2", hit_cnt); end
    $display("directed 3C/0C mask0F thr4/thr9: cnt=%0d", hit_cnt);
    // empty mask, threshold 0 then 1
    send(8'h12, 8'hED, 8'h00, 1'b0, 4'd0);
    step();
    checks++; if ({out_valid, sim, eq, hit} !== {1'b1, 4'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL d5_res: got ov=%b sim=%0d eq=%b hit=%b want 1 0 1 1", out_valid, sim, eq, hit); end
    send(8'h12, 8'hED, 8'h00, 1'b0, 4'd1);
    step();
    checks++; if ({out_valid, sim, eq, hit} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL d6_res: got ov=%b sim=%0d eq=%b hit=%b want 1 0 1 0", out_valid, sim, eq, hit); end
    $display("directed mask=00 thr0/thr1: sim=%0d eq=%b hit=%b", sim, eq, hit);
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_in(1'b1, 8'hA5, 8'hA5, 8'hFF, 1'b0, 4'd8);
    step();
    set_in(1'b1, 8'h00, 8'hFF, 8'hFF, 1'b0, 4'd8);
    step();
    checks++; if ({out_valid, y, sim, hit} !== {1'b1, 8'hFF, 4'd8, 1'b1}) begin errors++; $display("FAIL b2b_1: got ov=%b y=%h sim=%0d hit=%b want 1 FF 8 1", out_valid, y, sim, hit); end
    set_in(1'b1, 8'h0F, 8'h0F, 8'hFF, 1'b0, 4'd8);
    step();
    in_valid = 1'b0;
    checks++; if ({out_valid, y, sim, eq, hit} !== {1'b1, 8'h00, 4'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL b2b_2: got ov=%b y=%h sim=%0d eq=%b hit=%b want 1 00 0 0 0", out_valid, y, sim, eq, hit); end
    checks++; if (hit_cnt !== 16'd1) begin errors++; $display("FAIL b2b_cnt_mid: got %0d want 1", hit_cnt); end
    step();
    checks++; if ({out_valid, y, sim, hit} !== {1'b1, 8'hFF, 4'd8, 1'b1}) begin errors++; $display("FAIL b2b_3: got ov=%b y=%h sim=%0d hit=%b want 1 FF 8 1", out_valid, y, sim, hit); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", out_valid); end
    checks++; if (hit_cnt !== 16'd2) begin errors++; $display("FAIL b2b_cnt: got %0d want 2", hit_cnt); end
    $display("back_to_back three inputs: final cnt=%0d", hit_cnt);
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 4'd0);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    step();
    checks++; if (s_hit_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt: got %0d want 3", s_hit_cnt); end
    checks++; if (hit_cnt !== 16'd5) begin errors++; $display("FAIL sat_wide_cnt: got %0d want 5", hit_cnt); end
    $display("saturate five hits: cnt2=%0d cnt16=%0d", s_hit_cnt, hit_cnt);
    send(8'h55, 8'h55, 8'hFF, 1'b0, 4'd0);
    step();
    checks++; if ({out_valid, hit} !== 2'b11) begin errors++; $display("FAIL clr_hit: got ov=%b hit=%b want 1 1", out_valid, hit); end
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    checks++; if (s_hit_cnt !== 2'd0) begin errors++; $display("FAIL clr_cnt2: got %0d want 0", s_hit_cnt); end
    checks++; if (hit_cnt !== 16'd0) begin errors++; $display("FAIL clr_cnt16: got %0d want 0", hit_cnt); end
    checks++; if ({y, sim, eq, hit} !== {8'hFF, 4'd8, 1'b1, 1'b1}) begin errors++; $display("FAIL clr_outs: got y=%h sim=%0d eq=%b hit=%b want FF 8 1 1", y, sim, eq, hit); end
    $display("clear with simultaneous hit: cnt2=%0d cnt16=%0d", s_hit_cnt, hit_cnt);
  endtask

  task automatic test_reset_inflight();
    do_reset();
    send(8'hA5, 8'hA5, 8'hFF, 1'b0, 4'd1);
    step();
    step();
    set_in(1'b1, 8'h11, 8'h11, 8'hFF, 1'b1, 4'd1);
    step();
    set_in(1'b1, 8'h22, 8'h22, 8'hFF, 1'b0, 4'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({out_valid, y, sim, eq, hit} !== 15'd0) begin errors++; $display("FAIL inflight[%0d]: got ov=%b y=%h sim=%0d eq=%b hit=%b want all 0", k, out_valid, y, sim, eq, hit); end
      checks++; if (hit_cnt !== 16'd0) begin errors++; $display("FAIL inflight_cnt[%0d]: got %0d want 0", k, hit_cnt); end
      step();
    end
    send(8'hC3, 8'hC3, 8'hFF, 1'b0, 4'd8);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_early: got %b want 0", out_valid); end
    step();
    checks++; if ({out_valid, y, sim, hit} !== {1'b1, 8'hFF, 4'd8, 1'b1}) begin errors++; $display("FAIL post_rst: got ov=%b y=%h sim=%0d hit=%b want 1 FF 8 1", out_valid, y, sim, hit); end
    $display("reset with two in flight: first post-reset result ov=%b y=%h", out_valid, y);
  endtask

  task automatic test_random(input int n);
    exp_t q[$];
    exp_t last;
    exp_t e;
    logic exp_ov;
    int   cnt16 = 0;
    int   cnt2  = 0;
    int   cyc   = 0;
    logic iv, md, clr;
    logic [7:0] ra, rb, rm;
    logic [3:0] rt;
    do_reset();
    last = '{due: 0, y: 8'h00, sim: 4'd0, eq: 1'b0, hit: 1'b0};
    for (int i = 0; i < n + 3; i++) begin
      exp_ov = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        last   = q.pop_front();
        exp_ov = 1'b1;
      end
      checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL rnd_ov c%0d: got %b want %b", cyc, out_valid, exp_ov); end
      checks++; if ({y, sim, eq, hit} !== {last.y, last.sim, last.eq, last.hit}) begin errors++; $display("FAIL rnd_res c%0d: got y=%h sim=%0d eq=%b hit=%b want y=%h sim=%0d eq=%b hit=%b", cyc, y, sim, eq, hit, last.y, last.sim, last.eq, last.hit); end
      checks++; if (hit_cnt !== 16'(cnt16) || s_hit_cnt !== 2'(cnt2)) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d/%0d want %0d/%0d", cyc, hit_cnt, s_hit_cnt, cnt16, cnt2); end
      iv  = (i < n) && ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 15) == 0);
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? ra ^ 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rm = 8'h00;
        1:       rm = 8'hFF;
        default: rm = 8'($urandom);
      endcase
      md = 1'($urandom);
      rt = 4'($urandom_range(0, 15));
      if (clr) begin
        cnt16 = 0;
        cnt2  = 0;
      end else if (exp_ov && last.hit) begin
        cnt16 = (cnt16 < 65535) ? cnt16 + 1 : cnt16;
        cnt2  = (cnt2 < 3) ? cnt2 + 1 : cnt2;
      end
      if (iv) begin
        e     = model(ra, rb, rm, md, rt);
        e.due = cyc + 2;
        q.push_back(e);
      end
      set_in(iv, ra, rb, rm, md, rt);
      clr_cnt = clr;
      if (exp_ov) $display("rnd c%0d: y=%h sim=%0d eq=%b hit=%b cnt=%0d", cyc, last.y, last.sim, last.eq, last.hit, hit_cnt);
      step();
      cyc++;
    end
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain: %0d results never appeared, want 0", q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; clr_cnt = 1'b0;
    set_in(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_saturate();
    test_reset_inflight();
    test_random(300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
